linear_fixed_to_float_pipe: RTL and testbench
=============================================

# linear_fixed_to_float_pipe

Pipelined, multi-lane converter from signed linear fixed-point (Kulisch) accumulator values to the signed-float format (sign, isInf, isZero, signed exponent, fraction). It adds in-block round-to-nearest-even, post-rounding exponent overflow handling, a per-beat saturate/infinity mode and a valid/ready stream with backpressure. It sits between the accumulator drain and the float output/re-encode stage, with LANES conversions per beat.

## Interface
- ACC_NON_FRAC, 16, integer bits of accumulator magnitude
- ACC_FRAC, 16, fractional bits; TOTAL_ACC = ACC_NON_FRAC+ACC_FRAC+1 (incl. sign)
- EXP, 8, signed output exponent width; must be ≥ clog2(TOTAL_ACC)+1 and ≥ ADJUST_EXP_SIZE
- FRAC, 23, output fraction bits (hidden one excluded)
- LANES, 4, parallel conversions per beat
- ADJUST_EXP_SIZE, 8, signed exponent-adjust width

Ports:
- clock  in  1  sole clock
- resetn  in  1  asynchronous active-low reset
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_acc  in  LANES*TOTAL_ACC  two's-complement accumulators, lane 0 in LSBs
- in_is_inf, in_is_overflow, in_overflow_sign  in  LANES each  accumulator flags
- in_adjust  in  LANES*ADJUST_EXP_SIZE  signed exponent adjust per lane
- in_sat_mode  in  1  1 = overflow saturates to max; 0 = overflow gives inf
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_sign, out_inf, out_zero, out_inexact  out  LANES each
- out_exp  out  LANES*EXP; out_frac  out  LANES*FRAC

## Operation
- Per lane, magnitude m = |acc| over the low TOTAL_ACC-1 bits. clz = leading zeros of m. e = ACC_NON_FRAC-1-clz+sext(adjust).
- acc = −2^(TOTAL_ACC-1), whose magnitude is unrepresentable, is treated as overflow with sign 1.
- Normalise: m<<clz. Drop the leading one. The next FRAC bits are the fraction, followed by a guard bit and a sticky bit (OR of the rest).
- RNE: round up iff guard && (sticky || frac LSB). An all-ones fraction carries out: frac=0, e+1. inexact = guard|sticky.
- e is computed at EXP+2 bits, with no wrap. Overflow iff e > 2^(EXP-1)-1 after rounding. Underflow iff e < −2^(EXP-1); it produces zero with inexact=1 and sign kept.
- m==0 gives zero: exp=0, frac=0, inexact=0.
- Priority: in_is_inf → inf(sign). Else overflow (in_is_overflow, e overflow, or the most-negative case) → in_sat_mode ? max : inf.
  - Overflow sign = in_overflow_sign if in_is_overflow, else sign.
  - max = exp all-ones except MSB, frac all ones.
  - Overflow and inf cases give inexact=0.
- Else normal/zero as above.

## Timing
- 3 register stages:
  - S1: abs and flags.
  - S2: clz, shift and exponent.
  - S3: round and exceptions, which drive the outputs.
- Latency 3 cycles with out_ready=1. Throughput 1 beat/cycle.
- Each stage has a valid bit. A stage loads when it is empty or the downstream stage is advancing.
- in_ready = !S1.valid || S1 advancing. It is combinational from out_ready through the chain.
- Beat transfers only on valid&&ready.
- Output is held stable while out_valid && !out_ready. in_sat_mode and in_adjust are captured with their beat.
- Reset (async, any time, mid-pipe included): all valid bits 0 and all outputs 0. In-flight beats are discarded. in_ready=1 from the first cycle after deassertion.

## Structure
- Shared package lfp_pkg holds:
  - the TOTAL_ACC/clz-width helper functions;
  - the float-lane struct typedef (sign, isInf, isZero, exp, frac, inexact);
  - the max/inf constructors.
- One sub-module, lfp_round_rne: combinational FRAC+guard+sticky → rounded frac, carry and inexact. It is instantiated per lane in S3.
- The leading-zero counter is reused from the existing library.

## Test plan
Parameters for all cases: ACC_NON_FRAC=8, ACC_FRAC=8, FRAC=4, EXP=6, LANES=2, adjust 0 unless stated.
- acc 0x00100 → exp 0, frac 0000, inexact 0. Acc 0x00340 (3.25) → exp 1, frac 1010. Negative 3.25 (−0x340) → same with sign 1.
- RNE: acc 0x00108 → frac 0000, inexact 1 (tie to even). 0x00118 → frac 0010. 0x001F8 → exp 1, frac 0000 (carry).
- acc 0x00180 (exp 0) with adjust +31 → exp 31 fine. With adjust +32 → sat_mode 1 gives exp 31, frac 1111; sat_mode 0 gives inf. acc 0x00001 with adjust −25 → zero, inexact 1.
- in_is_overflow=1, overflow_sign=1 → max, negative. in_is_inf → inf. acc 0x10000 → overflow, sign 1. acc 0 → zero.
- Backpressure: stream 8 beats with out_ready toggling randomly. Require no loss or duplication, in-order output, and held data during stall.
- Assert resetn low with 3 beats in flight → out_valid 0 at once, no stale beat after release.

Source files
------------

// File: rtl/lfp_pkg.sv
// rtl/lfp_pkg.sv - shared width helpers, float-lane type and max/inf constructors
package lfp_pkg;

    localparam int LFP_EXP_MAX  = 32;
    localparam int LFP_FRAC_MAX = 64;

    // Sized for the widest supported configuration; lanes use the low EXP/FRAC bits.
    typedef struct packed {
        logic                          sign;
        logic                          is_inf;
        logic                          is_zero;
        logic signed [LFP_EXP_MAX-1:0] exp;
        logic [LFP_FRAC_MAX-1:0]       frac;
        logic                          inexact;
    } lfp_float_t;

    function automatic int total_acc(input int non_frac, input int frac);
        return non_frac + frac + 1;
    endfunction

    function automatic int clz_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic lfp_float_t lfp_make_inf(input logic sign);
        lfp_float_t r;
        r        = '0;
        r.sign   = sign;
        r.is_inf = 1'b1;
        return r;
    endfunction

    function automatic lfp_float_t lfp_make_max(input logic sign, input int exp_w, input int frac_w);
        lfp_float_t r;
        r      = '0;
        r.sign = sign;
        r.exp  = LFP_EXP_MAX'((1 << (exp_w - 1)) - 1);
        r.frac = {LFP_FRAC_MAX{1'b1}} >> (LFP_FRAC_MAX - frac_w);
        return r;
    endfunction

endpackage

// File: rtl/lfp_lzc.sv
// rtl/lfp_lzc.sv - leading-zero counter, returns W for an all-zero input
module lfp_lzc #(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) count_o = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/lfp_round_rne.sv
// rtl/lfp_round_rne.sv - round-to-nearest-even on fraction + guard + sticky
module lfp_round_rne #(
    parameter int FRAC = 23
) (
    input  logic [FRAC-1:0] frac_i,
    input  logic            guard_i,
    input  logic            sticky_i,
    output logic [FRAC-1:0] frac_o,
    output logic            carry_o,
    output logic            inexact_o
);

    logic round_up;

    assign round_up            = guard_i & (sticky_i | frac_i[0]);
    assign {carry_o, frac_o}   = {1'b0, frac_i} + {{FRAC{1'b0}}, round_up};
    assign inexact_o           = guard_i | sticky_i;

endmodule

// File: rtl/linear_fixed_to_float_pipe.sv
// rtl/linear_fixed_to_float_pipe.sv - 3-stage multi-lane Kulisch accumulator to signed-float converter
module linear_fixed_to_float_pipe
    import lfp_pkg::*;
#(
    parameter int ACC_NON_FRAC    = 16,
    parameter int ACC_FRAC        = 16,
    parameter int EXP             = 8,
    parameter int FRAC            = 23,
    parameter int LANES           = 4,
    parameter int ADJUST_EXP_SIZE = 8
) (
    input  logic                                            clock,
    input  logic                                            resetn,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [LANES*(ACC_NON_FRAC+ACC_FRAC+1)-1:0]      in_acc,
    input  logic [LANES-1:0]                                in_is_inf,
    input  logic [LANES-1:0]                                in_is_overflow,
    input  logic [LANES-1:0]                                in_overflow_sign,
    input  logic [LANES*ADJUST_EXP_SIZE-1:0]                in_adjust,
    input  logic                                            in_sat_mode,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [LANES-1:0]                                out_sign,
    output logic [LANES-1:0]                                out_inf,
    output logic [LANES-1:0]                                out_zero,
    output logic [LANES-1:0]                                out_inexact,
    output logic [LANES*EXP-1:0]                            out_exp,
    output logic [LANES*FRAC-1:0]                           out_frac
);

    localparam int TOTAL_ACC = total_acc(ACC_NON_FRAC, ACC_FRAC);
    localparam int MW        = TOTAL_ACC - 1;
    localparam int CW        = clz_width(MW);
    localparam int NW        = MW + FRAC + 2;
    localparam int EW        = max_int(EXP, ADJUST_EXP_SIZE) + 2;

    localparam logic signed [EW-1:0] E_MAX = EW'((1 << (EXP - 1)) - 1);
    localparam logic signed [EW-1:0] E_MIN = ~E_MAX;

    logic s1_v_q, s2_v_q, s3_v_q;
    logic s1_sat_q, s2_sat_q;
    logic ld_s1, ld_s2, ld_s3;

    // A stage loads when empty or when its contents move on this cycle.
    assign ld_s3     = !s3_v_q || out_ready;
    assign ld_s2     = !s2_v_q || ld_s3;
    assign ld_s1     = !s1_v_q || ld_s2;
    assign in_ready  = ld_s1;
    assign out_valid = s3_v_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s3_v_q   <= 1'b0;
            s1_sat_q <= 1'b0;
            s2_sat_q <= 1'b0;
        end else begin
            if (ld_s1) begin
                s1_v_q   <= in_valid;
                s1_sat_q <= in_sat_mode;
            end
            if (ld_s2) begin
                s2_v_q   <= s1_v_q;
                s2_sat_q <= s1_sat_q;
            end
            if (ld_s3) s3_v_q <= s2_v_q;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [TOTAL_ACC-1:0]        acc;
        logic [MW-1:0]               s1_m_d;
        logic                        s1_mneg_d;
        logic [MW-1:0]               s1_m_q;
        logic                        s1_sign_q, s1_mneg_q, s1_inf_q, s1_ovf_q, s1_ovfs_q;
        logic [ADJUST_EXP_SIZE-1:0]  s1_adj_q;

        assign acc       = in_acc[g*TOTAL_ACC +: TOTAL_ACC];
        assign s1_m_d    = acc[TOTAL_ACC-1] ? (~acc[MW-1:0] + MW'(1)) : acc[MW-1:0];
        // -2^(TOTAL_ACC-1) has no magnitude in MW bits and is flagged separately.
        assign s1_mneg_d = acc[TOTAL_ACC-1] && (acc[MW-1:0] == '0);

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                s1_m_q    <= '0;
                s1_sign_q <= 1'b0;
                s1_mneg_q <= 1'b0;
                s1_inf_q  <= 1'b0;
                s1_ovf_q  <= 1'b0;
                s1_ovfs_q <= 1'b0;
                s1_adj_q  <= '0;
            end else if (ld_s1 && in_valid) begin
                s1_m_q    <= s1_m_d;
                s1_sign_q <= acc[TOTAL_ACC-1];
                s1_mneg_q <= s1_mneg_d;
                s1_inf_q  <= in_is_inf[g];
                s1_ovf_q  <= in_is_overflow[g];
                s1_ovfs_q <= in_overflow_sign[g];
                s1_adj_q  <= in_adjust[g*ADJUST_EXP_SIZE +: ADJUST_EXP_SIZE];
            end
        end

        logic [CW-1:0]         clz;
        logic [MW-1:0]         norm;
        logic [NW-1:0]         ext;
        logic signed [EW-1:0]  s2_e_d;
        logic                  unused_lead;

        lfp_lzc #(.W(MW), .CW(CW)) u_lzc (
            .data_i  (s1_m_q),
            .count_o (clz)
        );

        assign norm        = s1_m_q << clz;
        assign ext         = {norm, {(FRAC + 2){1'b0}}};
        assign unused_lead = ext[NW-1];
        assign s2_e_d      = EW'(ACC_NON_FRAC - 1) - EW'(clz) + EW'(signed'(s1_adj_q));

        logic [FRAC-1:0]       s2_frac_q;
        logic                  s2_guard_q, s2_sticky_q, s2_zero_q;
        logic                  s2_sign_q, s2_mneg_q, s2_inf_q, s2_ovf_q, s2_ovfs_q;
        logic signed [EW-1:0]  s2_e_q;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                s2_frac_q   <= '0;
                s2_guard_q  <= 1'b0;
                s2_sticky_q <= 1'b0;
                s2_zero_q   <= 1'b0;
                s2_sign_q   <= 1'b0;
                s2_mneg_q   <= 1'b0;
                s2_inf_q    <= 1'b0;
                s2_ovf_q    <= 1'b0;
                s2_ovfs_q   <= 1'b0;
                s2_e_q      <= '0;
            end else if (ld_s2 && s1_v_q) begin
                s2_frac_q   <= ext[NW-2 -: FRAC];
                s2_guard_q  <= ext[NW-2-FRAC];
                s2_sticky_q <= |ext[NW-3-FRAC:0];
                s2_zero_q   <= (s1_m_q == '0);
                s2_sign_q   <= s1_sign_q;
                s2_mneg_q   <= s1_mneg_q;
                s2_inf_q    <= s1_inf_q;
                s2_ovf_q    <= s1_ovf_q;
                s2_ovfs_q   <= s1_ovfs_q;
                s2_e_q      <= s2_e_d;
            end
        end

        logic [FRAC-1:0]       r_frac;
        logic                  r_carry, r_inexact;
        logic signed [EW-1:0]  e_r;
        logic                  ov_sign;
        lfp_float_t            res_d;
        logic                  unused_res;

        lfp_round_rne #(.FRAC(FRAC)) u_rne (
            .frac_i    (s2_frac_q),
            .guard_i   (s2_guard_q),
            .sticky_i  (s2_sticky_q),
            .frac_o    (r_frac),
            .carry_o   (r_carry),
            .inexact_o (r_inexact)
        );

        assign e_r        = s2_e_q + $signed({{(EW - 1){1'b0}}, r_carry});
        assign ov_sign    = s2_ovf_q ? s2_ovfs_q : s2_sign_q;
        assign unused_res = ^res_d;

        always_comb begin
            res_d = '0;
            if (s2_inf_q) begin
                res_d = lfp_make_inf(s2_sign_q);
            end else if (s2_ovf_q || s2_mneg_q || (!s2_zero_q && (e_r > E_MAX))) begin
                res_d = s2_sat_q ? lfp_make_max(ov_sign, EXP, FRAC) : lfp_make_inf(ov_sign);
            end else if (s2_zero_q) begin
                res_d.sign    = s2_sign_q;
                res_d.is_zero = 1'b1;
            end else if (e_r < E_MIN) begin
                res_d.sign    = s2_sign_q;
                res_d.is_zero = 1'b1;
                res_d.inexact = 1'b1;
            end else begin
                res_d.sign    = s2_sign_q;
                res_d.exp     = LFP_EXP_MAX'(e_r);
                res_d.frac    = LFP_FRAC_MAX'(r_frac);
                res_d.inexact = r_inexact;
            end
        end

        logic             o_sign_q, o_inf_q, o_zero_q, o_inexact_q;
        logic [EXP-1:0]   o_exp_q;
        logic [FRAC-1:0]  o_frac_q;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                o_sign_q    <= 1'b0;
                o_inf_q     <= 1'b0;
                o_zero_q    <= 1'b0;
                o_inexact_q <= 1'b0;
                o_exp_q     <= '0;
                o_frac_q    <= '0;
            end else if (ld_s3 && s2_v_q) begin
                o_sign_q    <= res_d.sign;
                o_inf_q     <= res_d.is_inf;
                o_zero_q    <= res_d.is_zero;
                o_inexact_q <= res_d.inexact;
                o_exp_q     <= res_d.exp[EXP-1:0];
                o_frac_q    <= res_d.frac[FRAC-1:0];
            end
        end

        assign out_sign[g]               = o_sign_q;
        assign out_inf[g]                = o_inf_q;
        assign out_zero[g]               = o_zero_q;
        assign out_inexact[g]            = o_inexact_q;
        assign out_exp[g*EXP +: EXP]     = o_exp_q;
        assign out_frac[g*FRAC +: FRAC]  = o_frac_q;
    end

endmodule

// File: tb/tb_linear_fixed_to_float_pipe.sv
// tb/tb_linear_fixed_to_float_pipe.sv - directed self-checking bench for linear_fixed_to_float_pipe
module tb_linear_fixed_to_float_pipe;

    localparam int NF   = 8;
    localparam int FF   = 8;
    localparam int EXPW = 6;
    localparam int FRW  = 4;
    localparam int LN   = 2;
    localparam int ADJW = 8;
    localparam int TA   = NF + FF + 1;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [LN*TA-1:0]     in_acc = '0;
    logic [LN-1:0]        in_is_inf = '0;
    logic [LN-1:0]        in_is_overflow = '0;
    logic [LN-1:0]        in_overflow_sign = '0;
    logic [LN*ADJW-1:0]   in_adjust = '0;
    logic                 in_sat_mode = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [LN-1:0]        out_sign, out_inf, out_zero, out_inexact;
    logic [LN*EXPW-1:0]   out_exp;
    logic [LN*FRW-1:0]    out_frac;

    int total = 0;
    int bad   = 0;

    linear_fixed_to_float_pipe #(
        .ACC_NON_FRAC(NF), .ACC_FRAC(FF), .EXP(EXPW), .FRAC(FRW), .LANES(LN), .ADJUST_EXP_SIZE(ADJW)
    ) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_acc(in_acc), .in_is_inf(in_is_inf), .in_is_overflow(in_is_overflow),
        .in_overflow_sign(in_overflow_sign), .in_adjust(in_adjust), .in_sat_mode(in_sat_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_inf(out_inf),
        .out_zero(out_zero), .out_inexact(out_inexact), .out_exp(out_exp), .out_frac(out_frac)
    );

    always #5 clock = ~clock;

    function automatic logic [13:0] fl(input logic s, input logic i, input logic z, input logic x,
                                       input logic [5:0] e, input logic [3:0] f);
        return {s, i, z, x, e, f};
    endfunction

    function automatic logic [13:0] lane_obs(input int l);
        return {out_sign[l], out_inf[l], out_zero[l], out_inexact[l],
                out_exp[l*EXPW +: EXPW], out_frac[l*FRW +: FRW]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic beat(input string tag, input logic [TA-1:0] a0, input logic [TA-1:0] a1,
                        input logic [7:0] j0, input logic [7:0] j1, input logic [1:0] inf,
                        input logic [1:0] ovf, input logic [1:0] ovs, input logic sat,
                        input logic [13:0] e0, input logic [13:0] e1);
        int n;
        @(negedge clock);
        in_acc = {a1, a0};
        in_adjust = {j1, j0};
        in_is_inf = inf;
        in_is_overflow = ovf;
        in_overflow_sign = ovs;
        in_sat_mode = sat;
        in_valid = 1'b1;
        #1 chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clock);
        n = 0;
        do begin
            @(negedge clock);
            in_valid = 1'b0;
            in_sat_mode = ~sat;
            n++;
        end while (!out_valid && n < 10);
        #1;
        chk({tag, "_lat"}, 32'(n), 32'd3);
        chk({tag, "_l0"}, 32'(lane_obs(0)), 32'(e0));
        chk({tag, "_l1"}, 32'(lane_obs(1)), 32'(e1));
    endtask

    logic [13:0]  s_exp0 [8];
    logic [13:0]  s_exp1 [8];
    logic [28:0]  held;
    logic         held_v;
    logic [TA-1:0] tmp_acc;
    int sent, got, cyc, extra;

    initial begin
        repeat (2) @(negedge clock);
        #1 chk("reset_state", {out_valid, out_sign, out_inf, out_zero, out_inexact, out_exp, out_frac, in_ready},
                32'd1);
        @(negedge clock);
        resetn = 1'b1;
        #1 chk("post_reset_rdy", {out_valid, in_ready}, 32'b01);

        beat("a", 17'h00100, 17'h00340, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0,
             fl(0,0,0,0,6'd0,4'b0000), fl(0,0,0,0,6'd1,4'b1010));
        beat("b", 17'h1FCC0, 17'h00108, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0,
             fl(1,0,0,0,6'd1,4'b1010), fl(0,0,0,1,6'd0,4'b0000));
        beat("c", 17'h00118, 17'h001F8, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0,
             fl(0,0,0,1,6'd0,4'b0010), fl(0,0,0,1,6'd1,4'b0000));
        beat("d", 17'h00180, 17'h00180, 8'd31, 8'd32, 2'b00, 2'b00, 2'b00, 1'b1,
             fl(0,0,0,0,6'd31,4'b1000), fl(0,0,0,0,6'd31,4'b1111));
        beat("e", 17'h00180, 17'h1FFFF, 8'd32, 8'hE7, 2'b00, 2'b00, 2'b00, 1'b0,
             fl(0,1,0,0,6'd0,4'b0000), fl(1,0,1,1,6'd0,4'b0000));
        beat("f", 17'h00100, 17'h1FF00, 8'd0, 8'd0, 2'b10, 2'b01, 2'b01, 1'b1,
             fl(1,0,0,0,6'd31,4'b1111), fl(1,1,0,0,6'd0,4'b0000));
        beat("g", 17'h10000, 17'h00000, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0,
             fl(1,1,0,0,6'd0,4'b0000), fl(0,0,1,0,6'd0,4'b0000));
        beat("h", 17'h10000, 17'h1FF00, 8'd0, 8'd0, 2'b00, 2'b10, 2'b00, 1'b1,
             fl(1,0,0,0,6'd31,4'b1111), fl(0,0,0,0,6'd31,4'b1111));
        beat("i", 17'h00001, 17'h001F8, 8'hE8, 8'd30, 2'b00, 2'b00, 2'b00, 1'b0,
             fl(0,0,0,0,6'h20,4'b0000), fl(0,0,0,1,6'd31,4'b0000));
        beat("j", 17'h001F8, 17'h00000, 8'd31, 8'h7F, 2'b00, 2'b00, 2'b00, 1'b1,
             fl(0,0,0,0,6'd31,4'b1111), fl(0,0,1,0,6'd0,4'b0000));

        for (int k = 0; k < 8; k++) begin
            s_exp0[k] = fl(0,0,0,0,6'(k),4'b0000);
            s_exp1[k] = fl(0,0,0,0,6'(k+1),4'b1010);
        end
        in_is_inf = '0; in_is_overflow = '0; in_overflow_sign = '0; in_sat_mode = 1'b0;
        sent = 0; got = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (got < 8 && cyc < 200) begin
            @(negedge clock);
            out_ready = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (sent < 8) begin
                tmp_acc   = 17'h00100 << sent;
                in_acc    = {17'h00340, tmp_acc};
                in_adjust = {8'(sent), 8'd0};
                in_valid  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held_v)
                chk("stall_hold", {out_valid, out_sign, out_inf, out_zero, out_inexact, out_exp, out_frac},
                    32'(held));
            if (out_valid && out_ready) begin
                chk("stream_l0", 32'(lane_obs(0)), 32'(s_exp0[got & 7]));
                chk("stream_l1", 32'(lane_obs(1)), 32'(s_exp1[got & 7]));
                got++;
            end
            held_v = out_valid && !out_ready;
            held   = {out_valid, out_sign, out_inf, out_zero, out_inexact, out_exp, out_frac};
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        chk("stream_count", 32'(got), 32'd8);
        chk("stream_sent", 32'(sent), 32'd8);
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clock);
            #1 if (out_valid) extra++;
        end
        chk("stream_no_dup", 32'(extra), 32'd0);

        in_adjust = '0;
        in_acc = {17'h00340, 17'h00340};
        repeat (3) begin
            @(negedge clock);
            in_valid = 1'b1;
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1 chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 resetn = 1'b0;
        #1 chk("rst_out", {out_valid, out_sign, out_inf, out_zero, out_inexact, out_exp, out_frac}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        #1 chk("rst_rdy", 32'(in_ready), 32'd1);
        extra = 0;
        repeat (6) begin
            @(negedge clock);
            #1 if (out_valid) extra++;
        end
        chk("rst_no_stale", 32'(extra), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
